// File: rtl/rv32_pkg.sv
// -----------------------------------------------------------------------------
// rv32_pkg
// Shared definitions for the RiScKy instruction fetch stage: data width,
// canonical NOP encoding, default reset vector, the fetch FSM state type
// and a word-alignment helper.
// Configuration macro: RV32_FETCH_MISALIGN_TRAP_EN adds the S_TRAP state.
// -----------------------------------------------------------------------------
package rv32_pkg;

  localparam int          RV32_XLEN     = 32;
  localparam logic [31:0] RV32_NOP      = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic [31:0] RV32_RESET_PC = 32'h0000_0000;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_DROP = 3'd2,
    S_OUT  = 3'd3
`ifdef RV32_FETCH_MISALIGN_TRAP_EN
    ,
    S_TRAP = 3'd4
`endif
  } fetch_state_e;

  // Clear the byte-offset bits so the address points at a 32-bit word.
  function automatic logic [31:0] rv32_word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/rv32_pc_gen.sv
// -----------------------------------------------------------------------------
// rv32_pc_gen
// Program counter for the fetch stage: PC register, +4 adder, redirect mux and
// target alignment handling.
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   load_i          : take target_i as the next PC (redirect)
//   target_i        : redirect target, may carry non-zero low bits
//   incr_i          : advance the PC by one word
//   pc_o            : current PC
//   pc_plus4_o      : current PC + 4 (modulo 2^32)
//   pc_next_o       : value the PC register takes at the next edge
//   misaligned_o    : target_i is not word aligned (only with the trap
//                     feature; otherwise tied 0)
// Configuration macro: RV32_FETCH_MISALIGN_TRAP_EN.
// -----------------------------------------------------------------------------
module rv32_pc_gen
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RV32_RESET_PC,
  parameter int          XLEN     = RV32_XLEN
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic [XLEN-1:0] target_i,
  input  logic            incr_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic [XLEN-1:0] pc_next_o,
  output logic            misaligned_o
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] target_aligned;

  // The adder wraps naturally at 2^32.
  assign pc_plus4_o     = pc_q + XLEN'(4);
  assign target_aligned = rv32_word_align(target_i);

  // A redirect overrides the sequential increment.
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = target_aligned;
    end else if (incr_i) begin
      pc_d = pc_plus4_o;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o      = pc_q;
  assign pc_next_o = pc_d;

`ifdef RV32_FETCH_MISALIGN_TRAP_EN
  assign misaligned_o = |target_i[1:0];
`else
  // Low target bits are dropped silently when the trap is not built in.
  logic unused_target_low;
  assign unused_target_low = ^target_i[1:0];
  assign misaligned_o      = 1'b0;
`endif

endmodule

// File: rtl/rv32_fetch_unit.sv
// -----------------------------------------------------------------------------
// rv32_fetch_unit
// Instruction fetch stage of the RiScKy core. Owns the PC, reads instruction
// words over a req/ack handshake and hands {instruction, PC} to decode over a
// valid/ready handshake. Redirects (taken branch/jump) flush held or in-flight
// fetches; an outstanding memory read is always allowed to complete.
//   i_clk, i_rst_n   : clock, asynchronous active-low reset
//   i_redirect       : one-cycle redirect pulse, target on i_redirect_pc
//   o_imem_req       : read request, held with o_imem_addr until i_imem_ack
//   i_imem_ack       : read data valid on i_imem_rdata this cycle
//   o_valid/i_ready  : decode handshake for o_instruction/o_pc/o_pc_plus4
//   o_misaligned     : sticky misaligned-redirect trap flag
// Configuration macro: RV32_FETCH_MISALIGN_TRAP_EN enables the misaligned
// redirect trap (S_TRAP); without it the low target bits are cleared.
// -----------------------------------------------------------------------------
module rv32_fetch_unit
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RV32_RESET_PC,
  parameter int          XLEN     = RV32_XLEN
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_ack,
  input  logic [XLEN-1:0] i_imem_rdata,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_instruction,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc_plus4,
  output logic            o_misaligned
);

  localparam logic [XLEN-1:0] RESET_PC_P4 = RESET_PC + XLEN'(4);

  fetch_state_e    state_q;
  logic            req_q;
  logic            valid_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] instr_q;
  logic [XLEN-1:0] pc_out_q;
  logic [XLEN-1:0] pc_plus4_q;

  logic            pc_load;
  logic            pc_incr;
  logic            tgt_misaligned;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] pc_next;

  // PC only advances when a fetched word is actually kept.
  always_comb begin
    pc_load = i_redirect;
    pc_incr = (state_q == S_REQ) && i_imem_ack && !i_redirect;
`ifdef RV32_FETCH_MISALIGN_TRAP_EN
    if (state_q == S_TRAP) begin
      pc_load = 1'b0;
    end
`endif
  end

  rv32_pc_gen #(
    .RESET_PC (RESET_PC),
    .XLEN     (XLEN)
  ) u_pc_gen (
    .clk_i        (i_clk),
    .rst_ni       (i_rst_n),
    .load_i       (pc_load),
    .target_i     (i_redirect_pc),
    .incr_i       (pc_incr),
    .pc_o         (pc),
    .pc_plus4_o   (pc_plus4),
    .pc_next_o    (pc_next),
    .misaligned_o (tgt_misaligned)
  );

`ifdef RV32_FETCH_MISALIGN_TRAP_EN
  logic misaligned_q;
`else
  logic unused_tgt_misaligned;
  assign unused_tgt_misaligned = tgt_misaligned;
`endif

  // addr_q is reloaded from pc_next whenever a new request starts, so it
  // always follows the PC including a redirect taken in the same cycle. It
  // is deliberately left alone while an abandoned request drains in S_DROP.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      req_q        <= 1'b0;
      valid_q      <= 1'b0;
      addr_q       <= RESET_PC;
      instr_q      <= RV32_NOP;
      pc_out_q     <= RESET_PC;
      pc_plus4_q   <= RESET_PC_P4;
`ifdef RV32_FETCH_MISALIGN_TRAP_EN
      misaligned_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q <= S_REQ;
          req_q   <= 1'b1;
          addr_q  <= pc_next;
        end

        S_REQ: begin
          if (i_redirect) begin
            if (i_imem_ack) begin
              // Returned word belongs to the old path: restart at the target.
              addr_q <= pc_next;
            end else begin
              state_q <= S_DROP;
            end
          end else if (i_imem_ack) begin
            state_q    <= S_OUT;
            req_q      <= 1'b0;
            valid_q    <= 1'b1;
            instr_q    <= i_imem_rdata;
            pc_out_q   <= pc;
            pc_plus4_q <= pc_plus4;
          end
        end

        S_DROP: begin
          if (i_imem_ack) begin
            state_q <= S_REQ;
            addr_q  <= pc_next;
          end
        end

        S_OUT: begin
          if (i_redirect || i_ready) begin
            state_q <= S_REQ;
            valid_q <= 1'b0;
            req_q   <= 1'b1;
            addr_q  <= pc_next;
          end
        end

`ifdef RV32_FETCH_MISALIGN_TRAP_EN
        S_TRAP: begin
          // Let a read that was outstanding at trap entry finish, then go quiet.
          if (i_imem_ack) begin
            req_q <= 1'b0;
          end
        end
`endif

        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase

`ifdef RV32_FETCH_MISALIGN_TRAP_EN
      // Misaligned redirect overrides the normal transition from any live
      // state. A request still waiting for its ack stays up until it lands.
      if ((state_q != S_TRAP) && i_redirect && tgt_misaligned) begin
        state_q      <= S_TRAP;
        valid_q      <= 1'b0;
        misaligned_q <= 1'b1;
        pc_out_q     <= i_redirect_pc;
        req_q        <= req_q && !i_imem_ack;
      end
`endif
    end
  end

  assign o_imem_req    = req_q;
  assign o_imem_addr   = addr_q;
  assign o_valid       = valid_q;
  assign o_instruction = instr_q;
  assign o_pc          = pc_out_q;
  assign o_pc_plus4    = pc_plus4_q;

`ifdef RV32_FETCH_MISALIGN_TRAP_EN
  assign o_misaligned = misaligned_q;
`else
  assign o_misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_rv32_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_rv32_fetch_unit
// Scoreboard bench for rv32_fetch_unit. Directed stimulus pushes the expected
// memory addresses and decode-side transfers into queues; two monitors pop and
// compare whenever the DUT completes a memory read or a decode handshake.
// A second instance with RESET_PC=32'hFFFF_FFFC covers PC wrap-around.
// Honours RV32_FETCH_MISALIGN_TRAP_EN for the misaligned-redirect case.
// -----------------------------------------------------------------------------
module tb_rv32_fetch_unit;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } exp_t;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;
  logic        valid;
  logic        ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic        misaligned;

  logic        w_rst_n;
  logic        w_redirect;
  logic [31:0] w_redirect_pc;
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_ack;
  logic [31:0] w_rdata;
  logic        w_valid;
  logic        w_ready;
  logic [31:0] w_instr;
  logic [31:0] w_pc;
  logic [31:0] w_pc4;
  logic        w_misaligned;

  int passed = 0;
  int total  = 0;
  int ack_delay = 0;
  int wait_cnt  = 0;

  exp_t        exp_q[$];
  logic [31:0] addr_exp_q[$];

  rv32_fetch_unit u_dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .o_imem_req    (req),
    .o_imem_addr   (addr),
    .i_imem_ack    (ack),
    .i_imem_rdata  (rdata),
    .o_valid       (valid),
    .i_ready       (ready),
    .o_instruction (instr),
    .o_pc          (pc),
    .o_pc_plus4    (pc4),
    .o_misaligned  (misaligned)
  );

  rv32_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .i_clk         (clk),
    .i_rst_n       (w_rst_n),
    .i_redirect    (w_redirect),
    .i_redirect_pc (w_redirect_pc),
    .o_imem_req    (w_req),
    .o_imem_addr   (w_addr),
    .i_imem_ack    (w_ack),
    .i_imem_rdata  (w_rdata),
    .o_valid       (w_valid),
    .i_ready       (w_ready),
    .o_instruction (w_instr),
    .o_pc          (w_pc),
    .o_pc_plus4    (w_pc4),
    .o_misaligned  (w_misaligned)
  );

  // Zero-wait memory for the wrap instance.
  assign w_ack         = w_req;
  assign w_rdata       = 32'hDEAD_0013;
  assign w_ready       = 1'b1;
  assign w_redirect    = 1'b0;
  assign w_redirect_pc = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0093;
    return {a[15:0], 16'h0013};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Memory model: acks after ack_delay waiting cycles of a request.
  always @(posedge clk) begin
    #2;
    if (req && rst_n) begin
      if (wait_cnt >= ack_delay) begin
        ack      = 1'b1;
        rdata    = mem_word(addr);
        wait_cnt = 0;
      end else begin
        ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      ack      = 1'b0;
      wait_cnt = 0;
    end
  end

  // Monitor: every completed memory read must hit the next expected address.
  always @(negedge clk) begin
    if (req && ack) begin
      if (addr_exp_q.size() == 0) begin
        check("imem_addr_unexpected", {1'b1, addr}, {1'b0, 32'h0});
      end else begin
        logic [31:0] ea;
        ea = addr_exp_q.pop_front();
        check("imem_addr", {96'h0, addr}, {96'h0, ea});
      end
    end
  end

  // Monitor: every decode handshake must deliver the next expected word.
  always @(negedge clk) begin
    if (valid && ready && !redirect) begin
      if (exp_q.size() == 0) begin
        check("decode_unexpected", {32'h1, instr, pc, pc4}, {32'h0, 96'h0});
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("decode_xfer", {32'h0, instr, pc, pc4}, {32'h0, e.instr, e.pc, e.pc4});
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; w_rst_n = 1'b0;
    redirect = 1'b0; redirect_pc = 32'h0;
    ready = 1'b1; ack = 1'b0; rdata = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_req",        {127'h0, req},        {127'h0, 1'b0});
    check("rst_valid",      {127'h0, valid},      {127'h0, 1'b0});
    check("rst_instr",      {96'h0, instr},       {96'h0, 32'h0000_0013});
    check("rst_pc",         {96'h0, pc},          {96'h0, 32'h0});
    check("rst_pc_plus4",   {96'h0, pc4},         {96'h0, 32'h4});
    check("rst_misaligned", {127'h0, misaligned}, {127'h0, 1'b0});

    // First fetch with zero-wait memory, then a decode stall.
    addr_exp_q.push_back(32'h0);
    exp_q.push_back('{32'h0000_0093, 32'h0, 32'h4});
    addr_exp_q.push_back(32'h4);
    exp_q.push_back('{32'h0004_0013, 32'h4, 32'h8});
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!valid && n < 8);
    check("first_valid_latency", 128'(n), 128'd2);
    @(posedge clk); #1;
    check("next_req_addr", {95'h0, req, addr}, {95'h0, 1'b1, 32'h4});
    ready = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      check("stall_hold", {29'h0, valid, req, instr, pc, pc4},
            {29'h0, 1'b1, 1'b0, 32'h0004_0013, 32'h4, 32'h8});
      @(posedge clk); #1;
    end

    // Slow memory: three wait cycles on address 8.
    addr_exp_q.push_back(32'h8);
    exp_q.push_back('{32'h0008_0013, 32'h8, 32'hC});
    ack_delay = 3;
    ready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      check("slow_ack_hold", {94'h0, req, addr, valid}, {94'h0, 1'b1, 32'h8, 1'b0});
      @(posedge clk); #1;
    end
    check("slow_ack_valid", {95'h0, valid, pc}, {95'h0, 1'b1, 32'h8});

    // Redirect to 0x100 while the read of 0xC is still outstanding.
    ack_delay = 2;
    addr_exp_q.push_back(32'hC);
    addr_exp_q.push_back(32'h100);
    exp_q.push_back('{32'h0100_0013, 32'h100, 32'h104});
    @(posedge clk); #1;
    redirect = 1'b1; redirect_pc = 32'h100;
    @(posedge clk); #1;
    redirect = 1'b0;
    check("drop_old_addr", {94'h0, req, addr, valid}, {94'h0, 1'b1, 32'hC, 1'b0});
    @(posedge clk); #1;
    check("drop_old_addr_2", {95'h0, req, addr}, {95'h0, 1'b1, 32'hC});
    @(posedge clk); #1;
    ack_delay = 0;
    check("redirect_req_addr", {95'h0, req, addr}, {95'h0, 1'b1, 32'h100});
    @(posedge clk); #1;
    check("redirect_out_pc", {95'h0, valid, pc}, {95'h0, 1'b1, 32'h100});

    // Redirect to 0x200 while 0x104 is held, with ready also high.
    addr_exp_q.push_back(32'h104);
    addr_exp_q.push_back(32'h200);
    exp_q.push_back('{32'h0200_0013, 32'h200, 32'h204});
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("held_before_redirect", {95'h0, valid, pc}, {95'h0, 1'b1, 32'h104});
    redirect = 1'b1; redirect_pc = 32'h200;
    @(posedge clk); #1;
    redirect = 1'b0;
    check("out_redirect_flush", {94'h0, valid, req, addr}, {94'h0, 1'b0, 1'b1, 32'h200});
    @(posedge clk); #1;
    check("out_redirect_pc", {63'h0, valid, pc, pc4}, {63'h0, 1'b1, 32'h200, 32'h204});
    addr_exp_q.push_back(32'h204);
    @(posedge clk); #1;
    ready = 1'b0;
    @(posedge clk); #1;

    // Redirect to a misaligned target coinciding with an ack.
    exp_q.push_back('{32'h0204_0013, 32'h204, 32'h208});
    addr_exp_q.push_back(32'h208);
    ready = 1'b1;
    @(posedge clk); #1;
    redirect = 1'b1; redirect_pc = 32'h102;
`ifdef RV32_FETCH_MISALIGN_TRAP_EN
    @(posedge clk); #1;
    redirect = 1'b0;
    check("trap_entry", {93'h0, misaligned, valid, req, pc}, {93'h0, 1'b1, 1'b0, 1'b0, 32'h102});
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("trap_quiet", {125'h0, misaligned, req, valid}, {125'h0, 1'b1, 1'b0, 1'b0});
    end
`else
    addr_exp_q.push_back(32'h100);
    exp_q.push_back('{32'h0100_0013, 32'h100, 32'h104});
    @(posedge clk); #1;
    redirect = 1'b0;
    check("align_mask_addr", {94'h0, misaligned, req, addr}, {94'h0, 1'b0, 1'b1, 32'h100});
    @(posedge clk); #1;
    check("align_mask_pc", {94'h0, valid, pc, misaligned}, {94'h0, 1'b1, 32'h100, 1'b0});
`endif

    // Asynchronous reset in the middle of a request.
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_clears", {29'h0, req, valid, misaligned, instr, pc, pc4},
          {29'h0, 1'b0, 1'b0, 1'b0, 32'h0000_0013, 32'h0, 32'h4});

    // Redirect during S_IDLE steers the very first fetch.
    redirect = 1'b1; redirect_pc = 32'h400;
    addr_exp_q.push_back(32'h400);
    exp_q.push_back('{32'h0400_0013, 32'h400, 32'h404});
    addr_exp_q.push_back(32'h404);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    redirect = 1'b0;
    check("idle_redirect_addr", {95'h0, req, addr}, {95'h0, 1'b1, 32'h400});
    @(posedge clk); #1;
    check("idle_redirect_pc", {95'h0, valid, pc}, {95'h0, 1'b1, 32'h400});
    @(posedge clk); #1;
    ready = 1'b0;
    @(posedge clk); #1;
    check("final_hold", {95'h0, valid, pc}, {95'h0, 1'b1, 32'h404});

    // PC wrap: RESET_PC = 0xFFFF_FFFC.
    @(negedge clk);
    w_rst_n = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!w_valid && n < 8);
    check("wrap_latency", 128'(n), 128'd2);
    check("wrap_first_out", {32'h0, w_pc, w_pc4, w_instr},
          {32'h0, 32'hFFFF_FFFC, 32'h0, 32'hDEAD_0013});
    @(posedge clk); #1;
    check("wrap_second_fetch", {95'h0, w_req, w_addr}, {95'h0, 1'b1, 32'h0});

    repeat (2) @(posedge clk);
    #1;
    check("addr_queue_drained", 128'(addr_exp_q.size()), 128'd0);
    check("xfer_queue_drained", 128'(exp_q.size()), 128'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rv32_fetch_unit.md
Name: rv32_fetch_unit

Overview:
- Instruction fetch stage of the RiScKy core; sits upstream of the instruction decoder/controller.
- Owns the PC, issues word reads to instruction memory over a req/ack handshake, and presents {instruction, PC} to decode over a valid/ready handshake.
- Accepts redirects (taken branch or jump, driven by the PCSel path). Flushes in-flight or held fetches on a redirect.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- XLEN, 32, address/data width (only 32 supported).

Ports:
- i_clk  in  1  core clock
- i_rst_n  in  1  asynchronous active-low reset
- i_redirect  in  1  one-cycle pulse: taken branch/jump (PCSel=1)
- i_redirect_pc  in  32  redirect target (ALU result)
- o_imem_req  out  1  instruction memory read request
- o_imem_addr  out  32  word address of the request
- i_imem_ack  in  1  read data valid this cycle
- i_imem_rdata  in  32  instruction word
- o_valid  out  1  o_instruction/o_pc valid to decode
- i_ready  in  1  decode accepts this cycle
- o_instruction  out  32  fetched instruction
- o_pc  out  32  PC of o_instruction
- o_pc_plus4  out  32  o_pc + 4, for jal/jalr writeback
- o_misaligned  out  1  misaligned redirect trap (feature only; tie 0 otherwise)

Behaviour:
- Reset (async, i_rst_n=0):
  - pc=RESET_PC; state=S_IDLE.
  - o_imem_req=0, o_valid=0, o_instruction=32'h0000_0013 (NOP), o_pc=RESET_PC, o_pc_plus4=RESET_PC+4, o_misaligned=0.
- FSM states: S_IDLE, S_REQ, S_DROP, S_OUT (plus S_TRAP with the optional feature).
- S_IDLE: one cycle after reset release -> S_REQ.
- S_REQ:
  - o_imem_req=1 and o_imem_addr=pc, both held stable until ack.
  - On a cycle with i_imem_ack=1: register rdata into o_instruction and pc into o_pc; pc<=pc+4; go to S_OUT.
  - If i_redirect and i_imem_ack are both 1 in that cycle: discard the data, pc<=i_redirect_pc, stay in S_REQ with the new address next cycle.
  - If i_redirect=1 without ack: pc<=i_redirect_pc, go to S_DROP.
- S_DROP:
  - Request stays asserted at the old address, because a memory transaction is never abandoned.
  - On ack: discard the data, go to S_REQ at the redirected pc.
  - A further redirect in S_DROP overwrites the pending target.
- S_OUT:
  - o_valid=1; all outputs held stable while i_ready=0.
  - On i_ready=1: o_valid<=0, go to S_REQ. Throughput is one instruction per 2 cycles minimum with zero-wait memory.
  - i_redirect in S_OUT has priority over i_ready: held instruction discarded, o_valid<=0, pc<=i_redirect_pc, go to S_REQ.
- Latency:
  - Reset release to first o_valid = 3 cycles with same-cycle ack (IDLE, REQ, OUT).
  - Redirect to first valid redirected instruction = 2 cycles minimum.
- Arithmetic: pc+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000. o_pc_plus4 wraps the same way.
- i_redirect in S_IDLE: updates pc; the first fetch uses the new pc.
- Without the feature, redirect targets have bits [1:0] forced to 0.
- Reset asserted mid-transaction: all state clears immediately. Instruction memory must tolerate the dropped request.

Optional Feature:
- Macro: RV32_FETCH_MISALIGN_TRAP_EN.
- Defined:
  - A redirect with i_redirect_pc[1:0]!=0 sets o_misaligned=1 and enters S_TRAP.
  - S_TRAP: no requests, o_valid=0. o_pc = faulting target (bits [1:0] kept). Exit only via reset.
  - Any fetch already in flight completes and is discarded.
- Undefined: low bits are cleared silently, o_misaligned is tied 0, and S_TRAP does not exist.

Decomposition:
- Package rv32_pkg: fetch state enum, RV32_NOP=32'h0000_0013, default RESET_PC constant, XLEN.
- Sub-module rv32_pc_gen: PC register, +4 adder, redirect mux, alignment masking/check. The FSM stays in rv32_fetch_unit.

Test Plan:
- Reset release, zero-wait memory returning 32'h0000_0093 at addr 0, i_ready=1 -> o_valid on cycle 3; o_pc=0, o_pc_plus4=4; next request at addr 4.
- i_ready=0 for 5 cycles with o_valid=1 -> o_instruction, o_pc and o_pc_plus4 stay constant; no new o_imem_req until ready.
- Ack delayed 3 cycles -> o_imem_addr stays at 32'h0000_0008 and o_imem_req stays 1 throughout; data captured only on ack.
- Redirect to 32'h0000_0100 in S_REQ without ack, ack 2 cycles later -> that data is discarded; the next request is at 32'h100 and o_pc=32'h100.
- Redirect to 32'h0000_0200 in S_OUT with i_ready=1 in the same cycle -> held instruction dropped; the next valid instruction has o_pc=32'h200.
- RESET_PC=32'hFFFF_FFFC -> first o_pc_plus4=0, second fetch at addr 0. With the feature defined, redirect to 32'h0000_0102 -> o_misaligned=1 and no further requests.
